// File: rtl/toggle_edge_monitor.sv
// rtl/toggle_edge_monitor.sv - rise/fall pulses, toggle count and rise-to-rise period of a T flip-flop Q
// Optional feature: define TOGGLE_SYNC_EN to add a synchronizer flop ahead of the sample flop.
module toggle_edge_monitor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Q_IN,
  input  logic             CLR,
  output logic             RISE,
  output logic             FALL,
  output logic [WIDTH-1:0] TOGGLE_CNT,
  output logic [WIDTH-1:0] PERIOD,
  output logic             PERIOD_VALID,
  output logic             SAT,
  output logic             TMO
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, MEASURE, TIMEOUT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             q_in_s;
  logic             src_vld;
  logic             q_r;
  logic             q_p;
  logic             primed;
  logic             rise_d;
  logic             fall_d;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] period_nxt;
  logic [WIDTH-1:0] toggle_nxt;
  logic             pv_nxt;
  logic             tmo_nxt;
  logic             sat_nxt;

`ifdef TOGGLE_SYNC_EN
  logic sync_ff;
  logic sync_vld;

  // sync_vld keeps the reset value of sync_ff from being taken as a real sample
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_ff  <= 1'b0;
      sync_vld <= 1'b0;
    end else begin
      sync_ff  <= Q_IN;
      sync_vld <= 1'b1;
    end
  end

  assign q_in_s  = sync_ff;
  assign src_vld = sync_vld;
`else
  assign q_in_s  = Q_IN;
  assign src_vld = 1'b1;
`endif

  // Until primed, q_p is loaded with the same sample as q_r so the first sample never looks like an edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_r    <= 1'b0;
      q_p    <= 1'b0;
      primed <= 1'b0;
    end else begin
      q_r <= q_in_s;
      if (CLR) begin
        q_p    <= q_r;
        primed <= 1'b0;
      end else if (!primed) begin
        q_p    <= q_in_s;
        primed <= src_vld;
      end else begin
        q_p <= q_r;
      end
    end
  end

  assign rise_d = primed &  q_r & ~q_p;
  assign fall_d = primed & ~q_r &  q_p;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (CLR) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (rise_d) state_nxt = MEASURE;
        MEASURE: if (!rise_d && cnt == ALL_ONES) state_nxt = TIMEOUT;
        TIMEOUT: if (rise_d) state_nxt = MEASURE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A rise arriving as cnt reaches all-ones still reports a period rather than a timeout
  always_comb begin
    cnt_nxt    = cnt;
    period_nxt = PERIOD;
    pv_nxt     = 1'b0;
    tmo_nxt    = TMO;
    if (CLR) begin
      cnt_nxt    = '0;
      period_nxt = '0;
      tmo_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE, TIMEOUT: begin
          if (rise_d) cnt_nxt = ONE;
        end
        MEASURE: begin
          if (rise_d) begin
            period_nxt = cnt;
            pv_nxt     = 1'b1;
            cnt_nxt    = ONE;
          end else if (cnt == ALL_ONES) begin
            tmo_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
        default: cnt_nxt = '0;
      endcase
    end
  end

  always_comb begin
    toggle_nxt = TOGGLE_CNT;
    sat_nxt    = SAT;
    if (CLR) begin
      toggle_nxt = '0;
      sat_nxt    = 1'b0;
    end else if ((rise_d || fall_d) && TOGGLE_CNT != ALL_ONES) begin
      toggle_nxt = TOGGLE_CNT + ONE;
      sat_nxt    = SAT | (TOGGLE_CNT == (ALL_ONES - ONE));
    end
  end

  // Edge pulses are not gated by CLR: an edge seen in the clear cycle still pulses
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RISE         <= 1'b0;
      FALL         <= 1'b0;
      TOGGLE_CNT   <= '0;
      PERIOD       <= '0;
      PERIOD_VALID <= 1'b0;
      SAT          <= 1'b0;
      TMO          <= 1'b0;
      cnt          <= '0;
    end else begin
      RISE         <= rise_d;
      FALL         <= fall_d;
      TOGGLE_CNT   <= toggle_nxt;
      PERIOD       <= period_nxt;
      PERIOD_VALID <= pv_nxt;
      SAT          <= sat_nxt;
      TMO          <= tmo_nxt;
      cnt          <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_toggle_edge_monitor.sv
// tb/tb_toggle_edge_monitor.sv - randomized bench for toggle_edge_monitor against an event-level model
module tb_toggle_edge_monitor;

  localparam int WIDTH = 8;
  localparam int MAX   = (1 << WIDTH) - 1;

  logic             CLK = 1'b0;
  logic             RST;
  logic             Q_IN;
  logic             CLR;
  logic             RISE;
  logic             FALL;
  logic [WIDTH-1:0] TOGGLE_CNT;
  logic [WIDTH-1:0] PERIOD;
  logic             PERIOD_VALID;
  logic             SAT;
  logic             TMO;

  toggle_edge_monitor #(.WIDTH(WIDTH)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .Q_IN         (Q_IN),
    .CLR          (CLR),
    .RISE         (RISE),
    .FALL         (FALL),
    .TOGGLE_CNT   (TOGGLE_CNT),
    .PERIOD       (PERIOD),
    .PERIOD_VALID (PERIOD_VALID),
    .SAT          (SAT),
    .TMO          (TMO)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
  endtask

  // Model: samples, pending edge seen between the last two samples, time of last reported rise
  bit m_ok, m_prev, m_pr, m_pf, m_meas, m_sat, m_tmo, m_pv, m_rise, m_fall;
  bit d_ok, d_x;
  int m_last, m_tog, m_per, step;

  task automatic model_reset();
    m_ok = 0; m_prev = 0; m_pr = 0; m_pf = 0; m_meas = 0; m_sat = 0; m_tmo = 0;
    m_pv = 0; m_rise = 0; m_fall = 0; d_ok = 0; d_x = 0;
    m_last = 0; m_tog = 0; m_per = 0;
  endtask

  task automatic model_step(input bit x_in, input bit clr, input bit rst);
    bit x;
    bit x_ok;
    if (rst) begin
      model_reset();
      return;
    end
    step++;
`ifdef TOGGLE_SYNC_EN
    x = d_x; x_ok = d_ok; d_x = x_in; d_ok = 1;
`else
    x = x_in; x_ok = 1;
`endif
    m_rise = m_pr;
    m_fall = m_pf;
    m_pv   = 0;
    if (clr) begin
      m_tog = 0; m_sat = 0; m_tmo = 0; m_per = 0; m_meas = 0;
      m_pr = 0; m_pf = 0; m_ok = 0;
    end else begin
      if ((m_pr || m_pf) && m_tog < MAX) begin
        m_tog++;
        if (m_tog == MAX) m_sat = 1;
      end
      if (m_pr) begin
        if (m_meas) begin
          m_per = step - m_last;
          m_pv  = 1;
        end
        m_meas = 1;
        m_last = step;
      end else if (m_meas && step - m_last >= MAX) begin
        m_tmo  = 1;
        m_meas = 0;
      end
      if (x_ok) begin
        m_pr   = m_ok && !m_prev && x;
        m_pf   = m_ok && m_prev && !x;
        m_ok   = 1;
        m_prev = x;
      end else begin
        m_pr = 0;
        m_pf = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step(Q_IN, CLR, RST);
    #1;
    check("RISE", RISE, m_rise);
    check("FALL", FALL, m_fall);
    check("TOGGLE_CNT", TOGGLE_CNT, m_tog);
    check("PERIOD", PERIOD, m_per);
    check("PERIOD_VALID", PERIOD_VALID, m_pv);
    check("SAT", SAT, m_sat);
    check("TMO", TMO, m_tmo);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic hold_q(input bit v, input int n);
    Q_IN = v;
    run(n);
  endtask

  initial begin
    step = 0;
    model_reset();
    RST = 1'b1; Q_IN = 1'b1; CLR = 1'b0;
    run(3);
    RST = 1'b0;
    run(10);

    repeat (8) begin
      hold_q(0, 5);
      hold_q(1, 5);
    end

    hold_q(0, 5);
    hold_q(1, 300);
    hold_q(0, 5);
    hold_q(1, 5);
    hold_q(0, 5);
    hold_q(1, 5);
    hold_q(0, 5);

    repeat (132) begin
      hold_q(1, 2);
      hold_q(0, 2);
    end
    CLR = 1'b1; run(1); CLR = 1'b0;
    run(5);

    Q_IN = 1'b0; run(4);
    Q_IN = 1'b1; run(1);
    CLR = 1'b1; run(1); CLR = 1'b0;
    hold_q(1, 5);
    hold_q(0, 5);
    hold_q(1, 5);
    hold_q(0, 5);
    hold_q(1, 5);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        RST = 1'b1;
        #1;
        check("RST_ASYNC_TOGGLE_CNT", TOGGLE_CNT, 0);
        check("RST_ASYNC_PERIOD", PERIOD, 0);
        run(2);
        RST = 1'b0;
      end
      Q_IN = ~Q_IN;
      CLR  = ($urandom_range(0, 40) == 0);
      run(1);
      CLR  = 1'b0;
      if ($urandom_range(0, 30) == 0) run(250 + $urandom_range(0, 10));
      else run($urandom_range(0, 12));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
